// File: rtl/iosched_pkg.sv
// Shared types and constants for the io_out pin-bus scheduler.
package iosched_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    DATA = 1'b1
  } state_e;

  localparam logic [3:0] HEADER_TAG  = 4'hF;
  localparam logic [7:0] ABORT_CODE  = 8'hEE;
  localparam logic [3:0] STALL_LIMIT = 4'd15;

  // Header byte: tag in the upper nibble, grantee index in the lower nibble.
  function automatic logic [7:0] make_header(input logic [3:0] id);
    return {HEADER_TAG, id};
  endfunction

endpackage

// File: rtl/io_out_scheduler_rr_arbiter.sv
// Combinational rotating-priority pick: first set request strictly after ptr, with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  int cand;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    // Scan the farthest offset first so the nearest set request is the last writer.
    for (int i = N; i >= 1; i--) begin
      cand = (int'(ptr) + i) % N;
      if (req[cand]) begin
        any = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/io_out_scheduler.sv
// Round-robin scheduler sharing the 8-bit io_out pad bus between NUM_REQ producers.
// Optional stall timeout with abort marker is enabled by defining IOSCHED_TIMEOUT_EN.
module io_out_scheduler
  import iosched_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          MAX_BURST = 4,
  parameter logic [7:0]  IDLE_CODE = 8'h00
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 io_out,
  output logic                       out_valid,
  output logic                       out_hdr,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int             GW        = $clog2(NUM_REQ);
  localparam int             CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

  state_e         state;
  logic [CW-1:0]  beat_cnt;
  logic [GW-1:0]  rr_ptr;
  logic           arb_any;
  logic [GW-1:0]  arb_idx;
  logic           xfer;
  logic           burst_end;
  logic [7:0]     grant_byte;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (arb_any),
    .idx (arb_idx)
  );

  assign xfer       = (state == DATA) && req_valid[grant_id];
  assign burst_end  = req_last[grant_id] || (beat_cnt == LAST_BEAT);
  assign grant_byte = req_data[8*grant_id +: 8];

  always_comb begin
    req_ready = '0;
    if (en && state == DATA) req_ready[grant_id] = 1'b1;
  end

`ifdef IOSCHED_TIMEOUT_EN
  logic [3:0] stall_cnt;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB;
      beat_cnt  <= '0;
      rr_ptr    <= GW'(NUM_REQ - 1);
      grant_id  <= '0;
      io_out    <= IDLE_CODE;
      out_valid <= 1'b0;
      out_hdr   <= 1'b0;
`ifdef IOSCHED_TIMEOUT_EN
      stall_cnt <= '0;
`endif
    end else if (en) begin
      unique case (state)
        ARB: begin
          if (arb_any) begin
            grant_id  <= arb_idx;
            rr_ptr    <= arb_idx;
            io_out    <= make_header(4'(arb_idx));
            out_valid <= 1'b1;
            out_hdr   <= 1'b1;
            beat_cnt  <= '0;
            state     <= DATA;
`ifdef IOSCHED_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end else begin
            io_out    <= IDLE_CODE;
            out_valid <= 1'b0;
            out_hdr   <= 1'b0;
          end
        end
        DATA: begin
          if (xfer) begin
            io_out    <= grant_byte;
            out_valid <= 1'b1;
            out_hdr   <= 1'b0;
            beat_cnt  <= beat_cnt + 1'b1;
            if (burst_end) state <= ARB;
`ifdef IOSCHED_TIMEOUT_EN
            stall_cnt <= '0;
          end else if (stall_cnt == STALL_LIMIT - 4'd1) begin
            // This stall edge is the fifteenth in a row: emit the abort marker.
            io_out    <= ABORT_CODE;
            out_valid <= 1'b1;
            out_hdr   <= 1'b1;
            stall_cnt <= '0;
            state     <= ARB;
          end else begin
            io_out    <= IDLE_CODE;
            out_valid <= 1'b0;
            out_hdr   <= 1'b0;
            stall_cnt <= stall_cnt + 4'd1;
          end
`else
          end else begin
            io_out    <= IDLE_CODE;
            out_valid <= 1'b0;
            out_hdr   <= 1'b0;
          end
`endif
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_io_out_scheduler.sv
// Directed self-checking bench for io_out_scheduler (NUM_REQ=4, MAX_BURST=4).
module tb_io_out_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  io_out;
  logic        out_valid;
  logic        out_hdr;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  // Producer queues: {last, data} per requester.
  logic [8:0]  pq [4][$];
  logic [11:0] exp_q [$];
  logic [3:0]  fire;

  io_out_scheduler #(.NUM_REQ(4), .MAX_BURST(4), .IDLE_CODE(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .io_out    (io_out),
    .out_valid (out_valid),
    .out_hdr   (out_hdr),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] e(input logic v, input logic h, input logic [1:0] g,
                                    input logic [7:0] d);
    return {v, h, g, d};
  endfunction

  function automatic logic [11:0] observed();
    return {out_valid, out_hdr, grant_id, io_out};
  endfunction

  task automatic drive_inputs();
    logic [8:0] head;
    for (int i = 0; i < 4; i++) begin
      head = 9'h000;
      if (pq[i].size() > 0) head = pq[i][0];
      req_valid[i]        = (pq[i].size() > 0);
      req_last[i]         = head[8];
      req_data[8*i +: 8]  = head[7:0];
    end
  endtask

  // One clock: capture handshakes before the edge, advance producers after it.
  task automatic tick();
    @(negedge clk);
    fire = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (fire[i]) void'(pq[i].pop_front());
    drive_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    #3;
    checks++;
    if (observed() !== e(0, 0, 0, 8'h00) || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %h ready %b, expected %h ready 0000",
               observed(), req_ready, e(0, 0, 0, 8'h00));
    end
    rst = 1'b1;
  endtask

  task automatic test_idle();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (observed() !== e(0, 0, 0, 8'h00) || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle[%0d]: got %h ready %b, expected %h ready 0000",
                 i, observed(), req_ready, e(0, 0, 0, 8'h00));
      end
    end
  endtask

  task automatic test_single_burst();
    pq[0].push_back({1'b0, 8'h11});
    pq[0].push_back({1'b1, 8'h22});
    drive_inputs();
    exp_q = '{e(1, 1, 0, 8'hF0), e(1, 0, 0, 8'h11), e(1, 0, 0, 8'h22), e(0, 0, 0, 8'h00)};
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL single_burst[%0d]: got %h expected %h", i, observed(), exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 6; b++) begin
      pq[1].push_back({b == 5, 8'h10 + 8'(b)});
      pq[3].push_back({b == 5, 8'h30 + 8'(b)});
    end
    drive_inputs();
    exp_q = '{e(1, 1, 1, 8'hF1), e(1, 0, 1, 8'h10), e(1, 0, 1, 8'h11), e(1, 0, 1, 8'h12),
              e(1, 0, 1, 8'h13), e(1, 1, 3, 8'hF3), e(1, 0, 3, 8'h30), e(1, 0, 3, 8'h31),
              e(1, 0, 3, 8'h32), e(1, 0, 3, 8'h33), e(1, 1, 1, 8'hF1), e(1, 0, 1, 8'h14),
              e(1, 0, 1, 8'h15), e(1, 1, 3, 8'hF3), e(1, 0, 3, 8'h34), e(1, 0, 3, 8'h35),
              e(0, 0, 3, 8'h00)};
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, observed(), exp_q[i]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    for (int b = 0; b < 5; b++) pq[2].push_back({b == 4, 8'hA0 + 8'(b)});
    drive_inputs();
    exp_q = '{e(1, 1, 2, 8'hF2), e(1, 0, 2, 8'hA0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL freeze_pre[%0d]: got %h expected %h", i, observed(), exp_q[i]);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL freeze_ready[%0d]: got %b expected 0000", i, req_ready);
      end
      tick();
      checks++;
      if (observed() !== e(1, 0, 2, 8'hA0)) begin
        errors++;
        $display("FAIL freeze_hold[%0d]: got %h expected %h", i, observed(), e(1, 0, 2, 8'hA0));
      end
    end
    en = 1'b1;
    // Beat count survives the freeze, so the cap falls after A3 and A4 gets its own grant.
    exp_q = '{e(1, 0, 2, 8'hA1), e(1, 0, 2, 8'hA2), e(1, 0, 2, 8'hA3), e(1, 1, 2, 8'hF2),
              e(1, 0, 2, 8'hA4), e(0, 0, 2, 8'h00)};
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL freeze_post[%0d]: got %h expected %h", i, observed(), exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int b = 0; b < 3; b++) pq[2].push_back({b == 2, 8'hB0 + 8'(b)});
    drive_inputs();
    exp_q = '{e(1, 1, 2, 8'hF2), e(1, 0, 2, 8'hB0)};
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_pre[%0d]: got %h expected %h", i, observed(), exp_q[i]);
      end
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (observed() !== e(0, 0, 0, 8'h00) || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async: got %h ready %b, expected %h ready 0000",
               observed(), req_ready, e(0, 0, 0, 8'h00));
    end
    pq[0].push_back({1'b1, 8'hC0});
    drive_inputs();
    rst = 1'b1;
    exp_q = '{e(1, 1, 0, 8'hF0), e(1, 0, 0, 8'hC0), e(1, 1, 2, 8'hF2), e(1, 0, 2, 8'hB1),
              e(1, 0, 2, 8'hB2), e(0, 0, 2, 8'h00)};
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_post[%0d]: got %h expected %h", i, observed(), exp_q[i]);
      end
    end
  endtask

`ifdef IOSCHED_TIMEOUT_EN
  task automatic test_timeout();
    pq[3].push_back({1'b0, 8'hD0});
    pq[1].push_back({1'b1, 8'hE0});
    drive_inputs();
    exp_q = '{e(1, 1, 3, 8'hF3), e(1, 0, 3, 8'hD0)};
    for (int i = 0; i < 14; i++) exp_q.push_back(e(0, 0, 3, 8'h00));
    exp_q.push_back(e(1, 1, 3, 8'hEE));
    exp_q.push_back(e(1, 1, 1, 8'hF1));
    exp_q.push_back(e(1, 0, 1, 8'hE0));
    exp_q.push_back(e(0, 0, 1, 8'h00));
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      checks++;
      if (observed() !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout[%0d]: got %h expected %h", i, observed(), exp_q[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_single_burst();
    test_back_to_back();
    test_enable_freeze();
    test_reset_mid_burst();
`ifdef IOSCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
